// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode and mul/div FSM types shared by the ALU files
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_NOR   = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SLTU  = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULT  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_DIVU  = 4'b1011,
        OP_MFHI  = 4'b1100,
        OP_MFLO  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_FIX
    } md_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider with HI/LO
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  mq_q, mq_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic          is_div_q, is_div_d;
    logic          neg_q, neg_d;
    logic          rneg_q, rneg_d;
    logic          div0_q, div0_d;
    logic [N-1:0]  hi_q, hi_d;
    logic [N-1:0]  lo_q, lo_d;
    logic          done_q, done_d;

    logic          signed_op;
    logic [N-1:0]  a_mag, b_mag;
    logic [N:0]    mul_sum;
    logic [N:0]    div_shift;
    logic          div_ge;
    logic [N-1:0]  div_sub;
    logic [2*N-1:0] prod_mag, prod_fix;
    logic [N-1:0]  quot_fix, rem_fix;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag     = (signed_op && a[N-1]) ? -a : a;
    assign b_mag     = (signed_op && b[N-1]) ? -b : b;

    // acc holds the running high product half or the partial remainder; mq holds
    // the multiplier being shifted out or the dividend/quotient shifting through.
    assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dvs_q} : {(N+1){1'b0}});
    assign div_shift = {acc_q, mq_q[N-1]};
    assign div_ge    = div_shift >= {1'b0, dvs_q};
    assign div_sub   = div_shift[N-1:0] - dvs_q;

    assign prod_mag  = {acc_q, mq_q};
    assign prod_fix  = neg_q  ? -prod_mag : prod_mag;
    assign quot_fix  = neg_q  ? -mq_q     : mq_q;
    assign rem_fix   = rneg_q ? -acc_q    : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        dvs_d    = dvs_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start && is_muldiv(op)) begin
                    state_d  = MD_RUN;
                    cnt_d    = CNT_LAST;
                    acc_d    = '0;
                    mq_d     = a_mag;
                    dvs_d    = b_mag;
                    is_div_d = op[1];
                    neg_d    = signed_op && (a[N-1] ^ b[N-1]);
                    rneg_d   = signed_op && a[N-1];
                    div0_d   = (b == '0);
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    acc_d = div_ge ? div_sub : div_shift[N-1:0];
                    mq_d  = {mq_q[N-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[N:1];
                    mq_d  = {mul_sum[0], mq_q[N-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // A zero divisor leaves |a| in the remainder; sign fix restores a.
                    lo_d = div0_q ? '1 : quot_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            dvs_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            dvs_q    <= dvs_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != MD_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - MIPS-style combinational ALU with attached mul/div unit and HI/LO
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   alucontrol,
    input  logic         start,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         overflow,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    logic [N-1:0] sum;
    logic [N-1:0] diff;
    logic         lt_s;
    logic         lt_u;

    assign sum  = a + b;
    assign diff = a - b;
    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    muldiv_unit #(.N(N)) u_muldiv (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (alucontrol),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always_comb begin
        result = '0;
        case (alucontrol)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = sum;
            OP_NOR:  result = ~(a | b);
            OP_XOR:  result = a ^ b;
            OP_SLTU: result = {{(N-1){1'b0}}, lt_u};
            OP_SUB:  result = diff;
            OP_SLT:  result = {{(N-1){1'b0}}, lt_s};
            OP_MFHI: result = hi;
            OP_MFLO: result = lo;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

    // Signed overflow: operands effectively of equal sign, result sign differs from a.
    always_comb begin
        overflow = 1'b0;
        if (alucontrol == OP_ADD) begin
            overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
        end else if (alucontrol == OP_SUB) begin
            overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
        end
    end

endmodule
